// File: rtl/rbi_tlb_cmd_inject.sv
// rbi_tlb_cmd_inject
// Queues CPU-issued LDTLB/INVTLB commands and merges them into the L1->TLB
// ringbus request stream by replacing IDLE slots. L1 traffic passes through
// with one registered cycle of latency and is never dropped or reordered.
module rbi_tlb_cmd_inject #(
   parameter int DEPTH      = 4,
   parameter int GAP        = 1,
   parameter int STARVE_LIM = 16
) (
   input  logic          clock,
   input  logic          reset,

   input  logic [47:0]   regInAddr,
   input  logic [127:0]  regInData,
   input  logic [15:0]   regInOpm,
   input  logic [15:0]   regInSeq,
   input  logic          regInHold,

   input  logic          regInCmdValid,
   input  logic [7:0]    regInCmdOpm,
   input  logic [127:0]  regInCmdData,
   output logic          regOutCmdReady,
   output logic          regOutCmdErr,

   output logic [47:0]   regOutAddr,
   output logic [127:0]  regOutData,
   output logic [15:0]   regOutOpm,
   output logic [15:0]   regOutSeq,
   output logic          regOutWantSlot,
   output logic [15:0]   regOutInjCnt
);

   localparam logic [7:0] JX2_RBI_OPM_IDLE   = 8'h00;
   localparam logic [7:0] JX2_RBI_OPM_LDTLB  = 8'h1C;
   localparam logic [7:0] JX2_RBI_OPM_INVTLB = 8'h1D;

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

   // Command storage (data path only, no reset needed)
   logic [7:0]    cmdOpmQ  [DEPTH];
   logic [127:0]  cmdDataQ [DEPTH];

   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [CW-1:0] count;
   logic [GW-1:0] gapCnt;
   logic [SW-1:0] starveCnt;

   logic          cmdAccept;
   logic          cmdLegal;
   logic          doPush;
   logic          nonEmpty;
   logic          doInject;
   logic [7:0]    headOpm;
   logic [127:0]  headData;
   logic [47:0]   injAddr;
   logic [CW-1:0] countNext;
   logic [SW-1:0] starveNext;
   logic [GW-1:0] gapNext;

   assign regOutCmdReady = (count != COUNT_FULL);

   // Push/pop decisions and next-state values for the counters
   always_comb begin
      cmdAccept  = regInCmdValid && regOutCmdReady;
      cmdLegal   = (regInCmdOpm == JX2_RBI_OPM_LDTLB) ||
                   (regInCmdOpm == JX2_RBI_OPM_INVTLB);
      doPush     = cmdAccept && cmdLegal;
      nonEmpty   = (count != '0);
      doInject   = !regInHold && nonEmpty &&
                   (regInOpm[7:0] == JX2_RBI_OPM_IDLE) && (gapCnt == '0);
      headOpm    = cmdOpmQ[rdPtr];
      headData   = cmdDataQ[rdPtr];
      injAddr    = (headOpm == JX2_RBI_OPM_LDTLB) ? headData[111:64] : '0;

      countNext  = count;
      if (doPush && !doInject)
         countNext = count + CW'(1);
      else if (!doPush && doInject)
         countNext = count - CW'(1);

      gapNext    = gapCnt;
      starveNext = starveCnt;
      if (!regInHold) begin
         if (doInject)
            gapNext = GAP_LOAD;
         else if (gapCnt != '0)
            gapNext = gapCnt - GW'(1);

         if (doInject || !nonEmpty)
            starveNext = '0;
         else if (starveCnt != STARVE_MAX)
            starveNext = starveCnt + SW'(1);
      end
   end

   // FIFO storage write
   always_ff @(posedge clock) begin
      if (doPush) begin
         cmdOpmQ[wrPtr]  <= regInCmdOpm;
         cmdDataQ[wrPtr] <= regInCmdData;
      end
   end

   // FIFO pointers, occupancy, gap/starve counters and error pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr          <= '0;
         rdPtr          <= '0;
         count          <= '0;
         gapCnt         <= '0;
         starveCnt      <= '0;
         regOutCmdErr   <= 1'b0;
         regOutWantSlot <= 1'b0;
      end else begin
         if (doPush)
            wrPtr <= wrPtr + PW'(1);
         if (doInject)
            rdPtr <= rdPtr + PW'(1);
         count          <= countNext;
         gapCnt         <= gapNext;
         starveCnt      <= starveNext;
         regOutCmdErr   <= cmdAccept && !cmdLegal;
         // Registered from next-state so it tracks the starve counter exactly
         regOutWantSlot <= (starveNext == STARVE_MAX) && (countNext != '0);
      end
   end

   // Output stream register: inject a queued command or pass the L1 slot
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regOutAddr   <= '0;
         regOutData   <= '0;
         regOutOpm    <= '0;
         regOutSeq    <= '0;
         regOutInjCnt <= '0;
      end else if (!regInHold) begin
         if (doInject) begin
            regOutAddr   <= injAddr;
            regOutData   <= headData;
            regOutOpm    <= {8'h00, headOpm};
            regOutSeq    <= '0;
            regOutInjCnt <= regOutInjCnt + 16'd1;
         end else begin
            regOutAddr   <= regInAddr;
            regOutData   <= regInData;
            regOutOpm    <= regInOpm;
            regOutSeq    <= regInSeq;
         end
      end
   end

endmodule

// File: tb/tb_rbi_tlb_cmd_inject.sv
// Directed bench for rbi_tlb_cmd_inject with hand-computed expectations.
module tb_rbi_tlb_cmd_inject;

   localparam logic [7:0] OPM_IDLE   = 8'h00;
   localparam logic [7:0] OPM_LDTLB  = 8'h1C;
   localparam logic [7:0] OPM_INVTLB = 8'h1D;
   localparam logic [7:0] OPM_RD     = 8'h13;

   logic          clock = 1'b0;
   logic          reset;
   logic [47:0]   regInAddr;
   logic [127:0]  regInData;
   logic [15:0]   regInOpm;
   logic [15:0]   regInSeq;
   logic          regInHold;
   logic          regInCmdValid;
   logic [7:0]    regInCmdOpm;
   logic [127:0]  regInCmdData;
   logic          regOutCmdReady;
   logic          regOutCmdErr;
   logic [47:0]   regOutAddr;
   logic [127:0]  regOutData;
   logic [15:0]   regOutOpm;
   logic [15:0]   regOutSeq;
   logic          regOutWantSlot;
   logic [15:0]   regOutInjCnt;

   int testsRun  = 0;
   int testsFail = 0;

   rbi_tlb_cmd_inject #(.DEPTH(4), .GAP(1), .STARVE_LIM(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .regInAddr      (regInAddr),
      .regInData      (regInData),
      .regInOpm       (regInOpm),
      .regInSeq       (regInSeq),
      .regInHold      (regInHold),
      .regInCmdValid  (regInCmdValid),
      .regInCmdOpm    (regInCmdOpm),
      .regInCmdData   (regInCmdData),
      .regOutCmdReady (regOutCmdReady),
      .regOutCmdErr   (regOutCmdErr),
      .regOutAddr     (regOutAddr),
      .regOutData     (regOutData),
      .regOutOpm      (regOutOpm),
      .regOutSeq      (regOutSeq),
      .regOutWantSlot (regOutWantSlot),
      .regOutInjCnt   (regOutInjCnt)
   );

   always #5 clock = ~clock;

   task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic setL1(input logic [7:0] opm, input logic [47:0] addr, input logic [15:0] seq);
      regInOpm  = {8'h00, opm};
      regInAddr = addr;
      regInSeq  = seq;
      regInData = {80'h0, addr};
   endtask

   function automatic logic [127:0] makeTlbe(input logic [47:0] va);
      return {16'hA5A5, va, 16'h5A5A, va};
   endfunction

   logic [47:0] vaTab [4];
   int unsigned expInj;

   initial begin
      vaTab[0] = 48'h0000_AAAA_1000;
      vaTab[1] = 48'h0000_BBBB_2000;
      vaTab[2] = 48'h0000_CCCC_3000;
      vaTab[3] = 48'h0000_DDDD_4000;
      expInj   = 0;

      reset = 1'b1;
      regInHold = 1'b0;
      regInCmdValid = 1'b0;
      regInCmdOpm = '0;
      regInCmdData = '0;
      setL1(OPM_IDLE, 48'h0, 16'h0);

      // Reset state
      #1;
      checkVal("rst_opm",   128'(regOutOpm), 128'h0);
      checkVal("rst_addr",  128'(regOutAddr), 128'h0);
      checkVal("rst_data",  regOutData, 128'h0);
      checkVal("rst_want",  128'(regOutWantSlot), 128'h0);
      checkVal("rst_inj",   128'(regOutInjCnt), 128'h0);
      checkVal("rst_err",   128'(regOutCmdErr), 128'h0);
      checkVal("rst_ready", 128'(regOutCmdReady), 128'h1);
      tick();
      reset = 1'b0;
      tick();

      // Pass-through of RD stream, one cycle latency
      for (int i = 0; i < 4; i++) begin
         setL1(OPM_RD, 48'h1000 + 48'(i), 16'(i + 1));
         tick();
         checkVal("pass_addr", 128'(regOutAddr), 128'(48'h1000 + 48'(i)));
         checkVal("pass_opm",  128'(regOutOpm), 128'(16'h0013));
         checkVal("pass_seq",  128'(regOutSeq), 128'(i + 1));
         checkVal("pass_data", regOutData, 128'(48'h1000 + 48'(i)));
      end
      checkVal("pass_inj", 128'(regOutInjCnt), 128'h0);

      // Single LDTLB into an IDLE stream
      setL1(OPM_IDLE, 48'h0, 16'h0);
      regInCmdValid = 1'b1;
      regInCmdOpm   = OPM_LDTLB;
      regInCmdData  = makeTlbe(48'h0000_1234_5000);
      tick();
      regInCmdValid = 1'b0;
      checkVal("ld1_pre_opm", 128'(regOutOpm), 128'h0);
      tick();
      expInj++;
      checkVal("ld1_opm",  128'(regOutOpm), 128'(16'h001C));
      checkVal("ld1_addr", 128'(regOutAddr), 128'h0000_1234_5000);
      checkVal("ld1_data", regOutData, makeTlbe(48'h0000_1234_5000));
      checkVal("ld1_seq",  128'(regOutSeq), 128'h0);
      checkVal("ld1_inj",  128'(regOutInjCnt), 128'(expInj));
      tick();
      checkVal("ld1_gap_opm", 128'(regOutOpm), 128'h0);

      // Fill the FIFO while L1 is busy, then drain into IDLE slots
      setL1(OPM_RD, 48'h3000, 16'h0030);
      for (int i = 0; i < 4; i++) begin
         regInCmdValid = 1'b1;
         regInCmdOpm   = OPM_LDTLB;
         regInCmdData  = makeTlbe(vaTab[i]);
         tick();
      end
      checkVal("fill_ready_full", 128'(regOutCmdReady), 128'h0);
      regInCmdData = makeTlbe(48'h0000_EEEE_5000);
      tick();
      checkVal("fill_ready_5th", 128'(regOutCmdReady), 128'h0);
      regInCmdValid = 1'b0;
      setL1(OPM_IDLE, 48'h0, 16'h0);
      for (int j = 0; j < 9; j++) begin
         tick();
         if (j % 2 == 0 && j < 8) begin
            expInj++;
            checkVal("drain_opm",  128'(regOutOpm), 128'(16'h001C));
            checkVal("drain_addr", 128'(regOutAddr), 128'(vaTab[j / 2]));
         end else begin
            checkVal("drain_idle", 128'(regOutOpm), 128'h0);
         end
         if (j == 0)
            checkVal("drain_ready", 128'(regOutCmdReady), 128'h1);
      end
      checkVal("drain_inj", 128'(regOutInjCnt), 128'(expInj));

      // Starvation: one command, L1 busy for 20 cycles
      setL1(OPM_RD, 48'h5000, 16'h0050);
      regInCmdValid = 1'b1;
      regInCmdOpm   = OPM_LDTLB;
      regInCmdData  = makeTlbe(48'h0000_7777_0000);
      tick();
      regInCmdValid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checkVal($sformatf("starve_want_%0d", k), 128'(regOutWantSlot), 128'(k >= 16));
      end
      setL1(OPM_IDLE, 48'h0, 16'h0);
      tick();
      expInj++;
      checkVal("starve_inj_opm",  128'(regOutOpm), 128'(16'h001C));
      checkVal("starve_inj_addr", 128'(regOutAddr), 128'h0000_7777_0000);
      checkVal("starve_want_off", 128'(regOutWantSlot), 128'h0);
      tick();

      // Hold freezes outputs with an injection pending
      setL1(OPM_RD, 48'h2222, 16'h0022);
      regInCmdValid = 1'b1;
      regInCmdOpm   = OPM_LDTLB;
      regInCmdData  = makeTlbe(48'h0000_0BAD_0000);
      tick();
      regInCmdValid = 1'b0;
      regInHold = 1'b1;
      setL1(OPM_IDLE, 48'h0, 16'h0);
      for (int h = 0; h < 3; h++) begin
         tick();
         checkVal("hold_opm",  128'(regOutOpm), 128'(16'h0013));
         checkVal("hold_addr", 128'(regOutAddr), 128'h2222);
         checkVal("hold_inj",  128'(regOutInjCnt), 128'(expInj));
      end
      regInHold = 1'b0;
      tick();
      expInj++;
      checkVal("hold_rel_opm",  128'(regOutOpm), 128'(16'h001C));
      checkVal("hold_rel_addr", 128'(regOutAddr), 128'h0000_0BAD_0000);
      checkVal("hold_rel_inj",  128'(regOutInjCnt), 128'(expInj));
      tick();

      // INVTLB carries a zero address
      regInCmdValid = 1'b1;
      regInCmdOpm   = OPM_INVTLB;
      regInCmdData  = makeTlbe(48'h0000_FFFF_0000);
      tick();
      regInCmdValid = 1'b0;
      tick();
      expInj++;
      checkVal("inv_opm",  128'(regOutOpm), 128'(16'h001D));
      checkVal("inv_addr", 128'(regOutAddr), 128'h0);
      checkVal("inv_data", regOutData, makeTlbe(48'h0000_FFFF_0000));
      tick();

      // Illegal command opm: error pulse, nothing queued
      regInCmdValid = 1'b1;
      regInCmdOpm   = 8'h05;
      regInCmdData  = makeTlbe(48'h0000_0505_0000);
      tick();
      regInCmdValid = 1'b0;
      checkVal("err_pulse", 128'(regOutCmdErr), 128'h1);
      checkVal("err_ready", 128'(regOutCmdReady), 128'h1);
      tick();
      checkVal("err_clear", 128'(regOutCmdErr), 128'h0);
      checkVal("err_no_inj_opm", 128'(regOutOpm), 128'h0);
      tick();
      checkVal("err_no_inj_cnt", 128'(regOutInjCnt), 128'(expInj));

      // Async reset with two INVTLBs queued
      setL1(OPM_RD, 48'h4444, 16'h0044);
      regInCmdValid = 1'b1;
      regInCmdOpm   = OPM_INVTLB;
      regInCmdData  = makeTlbe(48'h0000_1111_0000);
      tick();
      regInCmdData  = makeTlbe(48'h0000_2222_0000);
      tick();
      regInCmdValid = 1'b0;
      tick();
      checkVal("prerst_opm", 128'(regOutOpm), 128'(16'h0013));
      #2 reset = 1'b1;
      #1;
      checkVal("arst_opm",   128'(regOutOpm), 128'h0);
      checkVal("arst_addr",  128'(regOutAddr), 128'h0);
      checkVal("arst_inj",   128'(regOutInjCnt), 128'h0);
      checkVal("arst_ready", 128'(regOutCmdReady), 128'h1);
      tick();
      reset = 1'b0;
      setL1(OPM_IDLE, 48'h0, 16'h0);
      for (int r = 0; r < 4; r++) begin
         tick();
         checkVal("postrst_opm", 128'(regOutOpm), 128'h0);
         checkVal("postrst_inj", 128'(regOutInjCnt), 128'h0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
